// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
//
// Round-robin arbiter sharing one AXI-Lite write master port between NUM_REQ
// AXI-Lite write requesters. One complete AW/W/B transaction is owned at a
// time; requesters are never interleaved. Requester i occupies slice i of
// every packed s_axi_* vector. A requester asks for the bus with
// s_axi_awvalid only; W-valid on its own never requests.
//
// Ports:
//   axi_aclk, axi_aresetn        clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*              packed upstream requester channels
//   m_axi_aw*/w*/b*              single downstream master channels
//
// Optional feature (compile-time macro AXI_WR_ARB_TIMEOUT_EN):
//   When defined, a watchdog counts RESP cycles without a downstream B.
//   After TIMEOUT_CYCLES such cycles the granted requester receives a
//   synthetic error response (bresp=1), held until it accepts it; any late
//   downstream B is then ignored. When undefined, RESP waits indefinitely
//   and no counter exists.
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [NUM_REQ-1:0]              s_axi_awvalid,
    output logic [NUM_REQ-1:0]              s_axi_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [NUM_REQ-1:0]              s_axi_wvalid,
    output logic [NUM_REQ-1:0]              s_axi_wready,
    output logic [NUM_REQ-1:0]              s_axi_bresp,
    output logic [NUM_REQ-1:0]              s_axi_bvalid,
    input  logic [NUM_REQ-1:0]              s_axi_bready,
    output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic                            m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int GW     = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;

`ifdef AXI_WR_ARB_TIMEOUT_EN
    // Watchdog width: just wide enough for TIMEOUT_CYCLES, kept within 8..16.
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, TOUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
`endif

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            aw_hs, w_hs;
    logic [GW-1:0]   rr_pick;

`ifdef AXI_WR_ARB_TIMEOUT_EN
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    // Per-requester views of the packed payload buses, indexed by grant.
    logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr  [NUM_REQ];
    logic [STRB_W-1:0]     wstrb_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign awaddr_arr[gi] = s_axi_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]  = s_axi_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wstrb_arr[gi]  = s_axi_wstrb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    // Round-robin pick: lowest requesting index above last_grant wins;
    // if none, wrap around to the lowest requesting index at or below it.
    // Scanning downward lets the last match (the lowest index) stick.
    always_comb begin
        logic [GW-1:0] pick_hi;
        logic [GW-1:0] pick_lo;
        logic          found_hi;
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_axi_awvalid[i]) begin
                if (i > int'(last_grant_q)) begin
                    pick_hi  = GW'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo = GW'(i);
                end
            end
        end
        rr_pick = found_hi ? pick_hi : pick_lo;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
`ifdef AXI_WR_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
`ifdef AXI_WR_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // Outputs are purely a function of state, so reset drops them at once.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        s_axi_bresp   = '0;
        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
`ifdef AXI_WR_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (|s_axi_awvalid) begin
                    grant_d = rr_pick;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                m_axi_awaddr  = awaddr_arr[grant_q];
                m_axi_wdata   = wdata_arr[grant_q];
                m_axi_wstrb   = wstrb_arr[grant_q];
                m_axi_awvalid = s_axi_awvalid[grant_q] & ~aw_done_q;
                m_axi_wvalid  = s_axi_wvalid[grant_q] & ~w_done_q;
                s_axi_awready[grant_q] = m_axi_awready & ~aw_done_q;
                s_axi_wready[grant_q]  = m_axi_wready & ~w_done_q;
                aw_hs = m_axi_awvalid & m_axi_awready;
                w_hs  = m_axi_wvalid & m_axi_wready;
                // Both halves may finish in either order or together.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXI_WR_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end

            RESP: begin
                s_axi_bvalid[grant_q] = m_axi_bvalid;
                s_axi_bresp[grant_q]  = m_axi_bresp;
                m_axi_bready          = s_axi_bready[grant_q];
                if (m_axi_bvalid && s_axi_bready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
`ifdef AXI_WR_ARB_TIMEOUT_EN
                else if (!m_axi_bvalid) begin
                    // Count only cycles with no downstream response in sight.
                    if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = TOUT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
`endif
            end

`ifdef AXI_WR_ARB_TIMEOUT_EN
            TOUT: begin
                // Synthetic error response; m_axi_bready stays low so a
                // late downstream B is never consumed here.
                s_axi_bvalid[grant_q] = 1'b1;
                s_axi_bresp[grant_q]  = 1'b1;
                if (s_axi_bready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_arbiter
//
// Directed bench for axi_wr_arbiter (NUM_REQ=2). Stimulus pushes hand-computed
// expected AW, W and B events into queues; a monitor on the falling edge pops
// and compares whenever a handshake is visible on the DUT ports. A small
// downstream slave model provides configurable AW delay, W ready and B
// response. Timeout scenario is included when AXI_WR_ARB_TIMEOUT_EN is set.
// -----------------------------------------------------------------------------
module tb_axi_wr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int SW      = DW / 8;

    logic                   axi_aclk;
    logic                   axi_aresetn;
    logic [NUM_REQ*AW-1:0]  s_axi_awaddr;
    logic [NUM_REQ-1:0]     s_axi_awvalid;
    logic [NUM_REQ-1:0]     s_axi_awready;
    logic [NUM_REQ*DW-1:0]  s_axi_wdata;
    logic [NUM_REQ*SW-1:0]  s_axi_wstrb;
    logic [NUM_REQ-1:0]     s_axi_wvalid;
    logic [NUM_REQ-1:0]     s_axi_wready;
    logic [NUM_REQ-1:0]     s_axi_bresp;
    logic [NUM_REQ-1:0]     s_axi_bvalid;
    logic [NUM_REQ-1:0]     s_axi_bready;
    logic [AW-1:0]          m_axi_awaddr;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;
    logic [DW-1:0]          m_axi_wdata;
    logic [SW-1:0]          m_axi_wstrb;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;
    logic                   m_axi_bresp;
    logic                   m_axi_bvalid;
    logic                   m_axi_bready;

    axi_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(255)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    // ---------------- requester-side drive ----------------
    logic [AW-1:0] r_awaddr  [NUM_REQ];
    logic [DW-1:0] r_wdata   [NUM_REQ];
    logic [SW-1:0] r_wstrb   [NUM_REQ];
    logic          r_awvalid [NUM_REQ];
    logic          r_wvalid  [NUM_REQ];
    logic          r_bready  [NUM_REQ];

    always_comb begin
        s_axi_awaddr  = '0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_awvalid = '0;
        s_axi_wvalid  = '0;
        s_axi_bready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_axi_awaddr[i*AW +: AW] = r_awaddr[i];
            s_axi_wdata[i*DW +: DW]  = r_wdata[i];
            s_axi_wstrb[i*SW +: SW]  = r_wstrb[i];
            s_axi_awvalid[i]         = r_awvalid[i];
            s_axi_wvalid[i]          = r_wvalid[i];
            s_axi_bready[i]          = r_bready[i];
        end
    end

    // ---------------- downstream slave model ----------------
    int   aw_delay_cfg;
    logic w_ready_cfg, b_en_cfg, b_resp_cfg;
    int   aw_wait;
    logic got_aw, got_w, sl_bvalid;
    logic na, nw;

    assign m_axi_awready = (aw_wait >= aw_delay_cfg);
    assign m_axi_wready  = w_ready_cfg;
    assign m_axi_bvalid  = sl_bvalid;
    assign m_axi_bresp   = sl_bvalid & b_resp_cfg;
    assign na = got_aw | (m_axi_awvalid & m_axi_awready);
    assign nw = got_w  | (m_axi_wvalid & m_axi_wready);

    always @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            aw_wait   <= 0;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
            sl_bvalid <= 1'b0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
            else if (m_axi_awvalid && m_axi_awready) aw_wait <= 0;
            if (sl_bvalid && m_axi_bready) begin
                sl_bvalid <= 1'b0;
                got_aw    <= 1'b0;
                got_w     <= 1'b0;
            end else if (na && nw && !sl_bvalid) begin
                sl_bvalid <= b_en_cfg;
                got_aw    <= 1'b0;
                got_w     <= 1'b0;
            end else begin
                got_aw <= na;
                got_w  <= nw;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int req; logic [AW-1:0] addr; } aw_exp_t;
    typedef struct { int req; logic [DW-1:0] data; logic [SW-1:0] strb; } w_exp_t;
    typedef struct { int req; logic resp; } b_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    b_exp_t  b_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int idx;
        idx = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < NUM_REQ; i++) if (v[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic push_txn(input int req, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb,
                            input logic resp);
        aw_exp_t a;
        w_exp_t  w;
        b_exp_t  b;
        a.req = req; a.addr = addr;
        w.req = req; w.data = data; w.strb = strb;
        b.req = req; b.resp = resp;
        aw_q.push_back(a);
        w_q.push_back(w);
        b_q.push_back(b);
    endtask

    always @(negedge axi_aclk) begin
        if (axi_aresetn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) begin
                    check_eq("aw_unexpected", {56'd0, m_axi_awaddr}, 64'hFFFF);
                end else begin
                    aw_exp_t e;
                    e = aw_q.pop_front();
                    check_eq("aw_grant", 64'(onehot_idx(s_axi_awready)), 64'(e.req));
                    check_eq("aw_addr", {56'd0, m_axi_awaddr}, {56'd0, e.addr});
                    $display("AW req=%0d addr=0x%02h", e.req, m_axi_awaddr);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_q.size() == 0) begin
                    check_eq("w_unexpected", {32'd0, m_axi_wdata}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    w_exp_t e;
                    e = w_q.pop_front();
                    check_eq("w_grant", 64'(onehot_idx(s_axi_wready)), 64'(e.req));
                    check_eq("w_data", {32'd0, m_axi_wdata}, {32'd0, e.data});
                    check_eq("w_strb", {60'd0, m_axi_wstrb}, {60'd0, e.strb});
                    $display("W  req=%0d data=0x%08h strb=0x%0h", e.req, m_axi_wdata, m_axi_wstrb);
                end
            end
            if ((s_axi_bvalid & s_axi_bready) != '0) begin
                if (b_q.size() == 0) begin
                    check_eq("b_unexpected", {62'd0, s_axi_bvalid}, 64'd0);
                end else begin
                    b_exp_t e;
                    int     idx;
                    e   = b_q.pop_front();
                    idx = onehot_idx(s_axi_bvalid & s_axi_bready);
                    check_eq("b_req", 64'(idx), 64'(e.req));
                    check_eq("b_resp", {63'd0, (idx >= 0) ? s_axi_bresp[idx] : 1'bx},
                             {63'd0, e.resp});
                    $display("B  req=%0d resp=%0d", e.req, e.resp);
                end
            end
        end
    end

    // ---------------- requester transaction task ----------------
    task automatic do_write(input int i, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb,
                            input int bdelay, output int cyc, output int bwait);
        logic aw_left, w_left, aw_s, w_s, b_s;
        int   guard;
        cyc = 0; bwait = 0; guard = 0;
        r_awaddr[i] = addr; r_wdata[i] = data; r_wstrb[i] = strb;
        r_awvalid[i] = 1'b1; r_wvalid[i] = 1'b1;
        aw_left = 1'b1; w_left = 1'b1;
        while ((aw_left || w_left) && guard < 1000) begin
            @(negedge axi_aclk);
            aw_s = r_awvalid[i] & s_axi_awready[i];
            w_s  = r_wvalid[i] & s_axi_wready[i];
            @(posedge axi_aclk);
            cyc++; guard++;
            #1;
            if (aw_s) begin r_awvalid[i] = 1'b0; aw_left = 1'b0; end
            if (w_s)  begin r_wvalid[i]  = 1'b0; w_left  = 1'b0; end
        end
        r_awvalid[i] = 1'b0; r_wvalid[i] = 1'b0;
        check_eq("aw_w_handshake_bound", {62'd0, aw_left, w_left}, 64'd0);
        for (int d = 0; d < bdelay; d++) begin
            @(negedge axi_aclk);
            check_eq("bp_m_bready_low", {63'd0, m_axi_bready}, 64'd0);
            check_eq("bp_no_new_aw", {63'd0, m_axi_awvalid}, 64'd0);
            @(posedge axi_aclk);
            cyc++;
            #1;
        end
        r_bready[i] = 1'b1;
        b_s = 1'b0; guard = 0;
        while (!b_s && guard < 1000) begin
            @(negedge axi_aclk);
            b_s = s_axi_bvalid[i];
            if (!b_s) bwait++;
            @(posedge axi_aclk);
            cyc++; guard++;
            #1;
        end
        r_bready[i] = 1'b0;
        check_eq("b_handshake_bound", {63'd0, b_s}, 64'd1);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge axi_aclk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, w0, c1, w1, c2, w2, c3, w3;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_awaddr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
            r_awvalid[i] = 1'b0; r_wvalid[i] = 1'b0; r_bready[i] = 1'b0;
        end
        aw_delay_cfg = 0; w_ready_cfg = 1'b1; b_en_cfg = 1'b1; b_resp_cfg = 1'b0;
        axi_aresetn = 1'b0;
        tick(3);

        // Reset values of outputs
        check_eq("rst_m_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        check_eq("rst_m_wvalid",  {63'd0, m_axi_wvalid},  64'd0);
        check_eq("rst_m_bready",  {63'd0, m_axi_bready},  64'd0);
        check_eq("rst_s_ready",   {60'd0, s_axi_awready, s_axi_wready}, 64'd0);
        check_eq("rst_s_b",       {60'd0, s_axi_bvalid, s_axi_bresp}, 64'd0);
        check_eq("rst_m_payload", {m_axi_wstrb, m_axi_awaddr, m_axi_wdata}, 64'd0);
        axi_aresetn = 1'b1;
        tick(2);

        // Single request from requester 0: three-cycle best case
        push_txn(0, 8'h04, 32'h17, 4'hF, 1'b0);
        do_write(0, 8'h04, 32'h17, 4'hF, 0, c0, w0);
        check_eq("single_total_cycles", 64'(c0), 64'd3);
        check_eq("single_b_wait", 64'(w0), 64'd0);
        tick(2);

        // W before AW: AW ready delayed by 3 cycles, W accepted at once
        aw_delay_cfg = 3;
        push_txn(1, 8'h20, 32'hCAFE_0001, 4'h3, 1'b0);
        do_write(1, 8'h20, 32'hCAFE_0001, 4'h3, 0, c1, w1);
        // IDLE 1 + ADDR 4 (awready after 3 waiting cycles) + RESP 1
        check_eq("w_first_total_cycles", 64'(c1), 64'd6);
        aw_delay_cfg = 0;
        tick(2);

        // Contention: both hold awvalid; last grant was 1 so order is 0,1,0,1
        push_txn(0, 8'h00, 32'hA000_0000, 4'hF, 1'b0);
        push_txn(1, 8'h10, 32'hB000_0000, 4'hF, 1'b0);
        push_txn(0, 8'h00, 32'hA000_0001, 4'hF, 1'b0);
        push_txn(1, 8'h10, 32'hB000_0001, 4'hF, 1'b0);
        fork
            begin
                do_write(0, 8'h00, 32'hA000_0000, 4'hF, 0, c0, w0);
                do_write(0, 8'h00, 32'hA000_0001, 4'hF, 0, c0, w0);
            end
            begin
                do_write(1, 8'h10, 32'hB000_0000, 4'hF, 0, c1, w1);
                do_write(1, 8'h10, 32'hB000_0001, 4'hF, 0, c1, w1);
            end
        join
        tick(2);

        // Backpressure: requester 1 holds bready low 5 cycles, bresp=1;
        // requester 0 asks meanwhile and must wait for the B handshake.
        b_resp_cfg = 1'b1;
        push_txn(1, 8'h30, 32'h0000_BEEF, 4'h1, 1'b1);
        push_txn(0, 8'h40, 32'h0000_F00D, 4'h8, 1'b1);
        fork
            do_write(1, 8'h30, 32'h0000_BEEF, 4'h1, 5, c2, w2);
            begin
                tick(3);
                do_write(0, 8'h40, 32'h0000_F00D, 4'h8, 0, c3, w3);
            end
        join
        b_resp_cfg = 1'b0;
        tick(2);

        // Reset during ADDR: stall both channels, then pull reset mid-cycle
        aw_delay_cfg = 10; w_ready_cfg = 1'b0;
        r_awaddr[1] = 8'h55; r_awvalid[1] = 1'b1; r_wvalid[1] = 1'b1;
        r_awaddr[0] = 8'h66; r_awvalid[0] = 1'b1; r_wvalid[0] = 1'b1;
        tick(2);
        check_eq("pre_rst_in_addr", {63'd0, m_axi_awvalid}, 64'd1);
        #2;
        axi_aresetn = 1'b0;
        #1;
        check_eq("mid_rst_m_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        check_eq("mid_rst_m_wvalid",  {63'd0, m_axi_wvalid},  64'd0);
        check_eq("mid_rst_s_ready",   {60'd0, s_axi_awready, s_axi_wready}, 64'd0);
        check_eq("mid_rst_m_awaddr",  {56'd0, m_axi_awaddr}, 64'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            r_awvalid[i] = 1'b0; r_wvalid[i] = 1'b0;
        end
        aw_delay_cfg = 0; w_ready_cfg = 1'b1;
        tick(2);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        tick(1);
        // Both request after reset: requester 0 must win first
        push_txn(0, 8'h08, 32'h1111_0000, 4'hF, 1'b0);
        push_txn(1, 8'h18, 32'h2222_0000, 4'hF, 1'b0);
        fork
            do_write(0, 8'h08, 32'h1111_0000, 4'hF, 0, c0, w0);
            do_write(1, 8'h18, 32'h2222_0000, 4'hF, 0, c1, w1);
        join
        tick(2);

`ifdef AXI_WR_ARB_TIMEOUT_EN
        // Watchdog: downstream never answers -> synthetic error after 255 cycles
        b_en_cfg = 1'b0;
        push_txn(0, 8'h7C, 32'hDEAD_0000, 4'hF, 1'b1);
        do_write(0, 8'h7C, 32'hDEAD_0000, 4'hF, 0, c0, w0);
        check_eq("tmo_b_wait", 64'(w0), 64'd255);
        b_en_cfg = 1'b1;
        tick(2);
        // Back in IDLE: a normal transaction completes in 3 cycles
        push_txn(1, 8'h7D, 32'hDEAD_0001, 4'hF, 1'b0);
        do_write(1, 8'h7D, 32'hDEAD_0001, 4'hF, 0, c1, w1);
        check_eq("post_tmo_total_cycles", 64'(c1), 64'd3);
        tick(2);
`endif

        check_eq("aw_queue_drained", 64'(aw_q.size()), 64'd0);
        check_eq("w_queue_drained",  64'(w_q.size()),  64'd0);
        check_eq("b_queue_drained",  64'(b_q.size()),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Round-robin arbiter that shares one AXI-Lite write master port between NUM_REQ upstream AXI-Lite write requesters. It sits between several write sources and the slave side of the bus bridge. It owns the full AW/W/B sequence for one transaction at a time and never interleaves requesters. Requester ports are packed: requester i occupies slice i of every s_* vector.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 8, address width
TIMEOUT_CYCLES, 255, B-channel watchdog limit; used only with AXI_WR_ARB_TIMEOUT_EN

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  NUM_REQ*ADDR_WIDTH  requester write addresses
s_axi_awvalid  in  NUM_REQ  requester AW valid
s_axi_awready  out  NUM_REQ  AW ready to requesters
s_axi_wdata  in  NUM_REQ*DATA_WIDTH  requester write data
s_axi_wstrb  in  NUM_REQ*DATA_WIDTH/8  requester byte strobes
s_axi_wvalid  in  NUM_REQ  requester W valid
s_axi_wready  out  NUM_REQ  W ready to requesters
s_axi_bresp  out  NUM_REQ  write response (1 = error)
s_axi_bvalid  out  NUM_REQ  B valid to requesters
s_axi_bready  in  NUM_REQ  requester B ready
m_axi_awaddr  out  ADDR_WIDTH  forwarded address
m_axi_awvalid  out  1  forwarded AW valid
m_axi_awready  in  1  downstream AW ready
m_axi_wdata  out  DATA_WIDTH  forwarded data
m_axi_wstrb  out  DATA_WIDTH/8  forwarded strobes
m_axi_wvalid  out  1  forwarded W valid
m_axi_wready  in  1  downstream W ready
m_axi_bresp  in  1  downstream response
m_axi_bvalid  in  1  downstream B valid
m_axi_bready  out  1  B ready to downstream

Behaviour:
- Single clock axi_aclk. Reset axi_aresetn is asynchronous, active-low.
- Reset values: state=IDLE, grant=0, last_grant=NUM_REQ-1 (requester 0 wins first), aw_done=w_done=0.
- Reset values of outputs: all s_axi_*ready, s_axi_bvalid, m_axi_awvalid, m_axi_wvalid and m_axi_bready are 0. m_axi_awaddr, wdata, wstrb and s_axi_bresp are 0.
- Request i = s_axi_awvalid[i]. W-valid alone never requests.
- FSM IDLE: if any request is present, register grant = first requesting index after last_grant (modulo NUM_REQ), then go to ADDR. No outputs are driven in IDLE.
- FSM ADDR:
  - m_axi_awvalid = s_axi_awvalid[grant] & ~aw_done, and m_axi_wvalid = s_axi_wvalid[grant] & ~w_done.
  - Address, data and strobe are muxed combinationally from slice grant.
  - s_axi_awready[grant] = m_axi_awready & ~aw_done, and likewise for W. Non-granted readies are 0.
  - aw_done and w_done are set on their respective handshakes; AW and W may complete in either order or in the same cycle.
  - When both are done (including the same-cycle case), go to RESP and clear the flags.
- FSM RESP:
  - s_axi_bvalid[grant] = m_axi_bvalid and s_axi_bresp[grant] = m_axi_bresp; m_axi_bready = s_axi_bready[grant].
  - On the B handshake: last_grant <= grant, go to IDLE.
- Latency: minimum 1 cycle from awvalid to m_axi_awvalid (IDLE decision cycle). Best-case transaction is 3 cycles. A requester holding awvalid continuously gets at most one transaction per NUM_REQ grants when others contend.
- m_axi_bvalid outside RESP is ignored (m_axi_bready=0). Requester valids that drop during ADDR before handshake are forwarded as-is; the arbiter does not fabricate valids.
- A requester index with no pending request is skipped. If only one requester is active, it is re-granted back-to-back.
- Reset mid-transaction: all outputs drop to their reset values immediately, the FSM returns to IDLE, and the in-flight transaction is abandoned.

Optional Feature:
AXI_WR_ARB_TIMEOUT_EN:
- Defined: an 8..16-bit counter runs in RESP. If m_axi_bvalid has not been seen for TIMEOUT_CYCLES cycles, the arbiter drives s_axi_bvalid[grant]=1 with s_axi_bresp[grant]=1 (error) and holds until s_axi_bready[grant], then returns to IDLE. A late downstream B is then ignored. The counter is cleared on entering RESP and on reset.
- Undefined: RESP waits indefinitely and no counter is synthesized.

Test Plan:
- Single request: requester 0 issues awaddr=0x04, wdata=0x17, wstrb=0xF, downstream always ready, bresp=0 -> m_axi_awaddr=0x04 and wdata=0x17 one cycle after awvalid; requester 0 gets bvalid with bresp=0; total 3 cycles.
- Contention: requesters 0 and 1 both hold awvalid, with addrs 0x00 and 0x10, for 4 transactions -> grants alternate 0,1,0,1; no overlap on m_axi_*.
- W before AW: downstream wready=1 and awready delayed 3 cycles -> w_done set first, RESP is entered only after the AW handshake, and wdata is not re-sent.
- Backpressure: bready of requester 1 held low 5 cycles with m_axi_bvalid=1 and bresp=1 -> m_axi_bready stays 0, bresp=1 is delivered on release, and no new grant occurs meanwhile.
- Reset asserted during ADDR -> m_axi_awvalid, m_axi_wvalid and all readies are 0 asynchronously; after release requester 0 wins first.
- With AXI_WR_ARB_TIMEOUT_EN and downstream bvalid never asserted -> after 255 cycles in RESP the requester receives bvalid=1, bresp=1, and the FSM returns to IDLE.
